fetch_buffer: RTL and testbench

Parametrised instruction prefetch unit that replaces the combinational single-cycle fetch path of the hart. It issues in-order word requests to a latency-tolerant instruction memory, tracks requests in flight, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes instructions over a valid/ready handshake. A redirect from execute (taken branch or jump) flushes the buffer and discards stale responses.

---
 rtl/fetch_buffer_if.sv | 24 ++
 rtl/fetch_buffer.sv | 108 ++++++++++
 tb/tb_fetch_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-side bundle: instruction memory request/response, decode handshake and redirect.
interface fetch_buffer_if;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;

   modport master (
      output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready, i_redirect, i_redirect_pc
   );

   modport slave (
      input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready, i_redirect, i_redirect_pc
   );
endinterface

// File: rtl/fetch_buffer.sv
// In-order instruction prefetcher with a DEPTH-entry {inst, pc} FIFO; grant-to-valid is L+1 cycles.
// Requests stop when queued plus in-flight reaches DEPTH; redirect flushes and drops stale responses.
module fetch_buffer #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH      = 4
) (
   input logic            i_clk,
   input logic            i_rst,
   fetch_buffer_if.master bus
);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   fifo_inst_q [DEPTH];
   logic [31:0]   fifo_pc_q   [DEPTH];

   logic        req, gnt_fire, rsp, push, inst_valid, pop;
   logic [31:0] redirect_pc_al;
   logic        redirect_pc_lsb_unused;

   assign redirect_pc_al         = {bus.i_redirect_pc[31:2], 2'b00};
   assign redirect_pc_lsb_unused = ^bus.i_redirect_pc[1:0];

   // Credit counts both buffered entries and requests whose responses are still owed.
   assign req        = ~i_rst & ~bus.i_redirect & (({1'b0, count_q} + {1'b0, outst_q}) < CAP);
   assign gnt_fire   = req & bus.i_imem_gnt;
   assign rsp        = bus.i_imem_rvalid;
   assign push       = rsp & ~bus.i_redirect & (drop_q == '0);
   assign inst_valid = (count_q != '0) & ~bus.i_redirect;
   assign pop        = inst_valid & bus.i_inst_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (bus.i_redirect) begin
         fetch_pc_d = redirect_pc_al;
         resp_pc_d  = redirect_pc_al;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Everything still owed after this cycle belongs to the old stream.
         outst_d    = outst_q - CW'(rsp);
         drop_d     = outst_q - CW'(rsp);
      end else begin
         if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         outst_d = outst_q + CW'(gnt_fire) - CW'(rsp);
         if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q <= RESET_ADDR;
         resp_pc_q  <= RESET_ADDR;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= bus.i_imem_rdata;
         fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

   assign bus.o_imem_req   = req;
   assign bus.o_imem_addr  = fetch_pc_q;
   assign bus.o_inst_valid = inst_valid;
   assign bus.o_inst       = fifo_inst_q[rd_ptr_q];
   assign bus.o_inst_pc    = fifo_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: an in-order latency-tolerant memory plus a queue-based model of the fetch stream.
module tb_fetch_buffer;
   localparam logic [31:0] RA    = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_buffer_if bus();

   fetch_buffer #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } req_t;

   req_t        pend[$];
   logic [31:0] mfifo[$];
   logic [31:0] next_pc;
   int epoch, last_due, cyc, dut_grants, valid_seen;
   int n_checks, n_err;
   int k_gnt, k_rdy, k_redir, k_lmin, k_lmax;
   bit f_redir;
   logic [31:0] f_redir_pc;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
      k_gnt = g; k_rdy = r; k_redir = rd; k_lmin = lmin; k_lmax = lmax;
   endtask

   // One clock: drive at +1, compare and advance the model at the falling edge.
   task automatic run_cycle();
      bit   exp_req, exp_valid, fire, pop, redir;
      int   lat;
      req_t e;
      @(posedge clk); #1;
      cyc++;
      rst = 1'b0;
      bus.i_imem_gnt   = ($urandom_range(99) < k_gnt);
      bus.i_inst_ready = ($urandom_range(99) < k_rdy);
      if (f_redir) begin
         bus.i_redirect    = 1'b1;
         bus.i_redirect_pc = f_redir_pc;
         f_redir           = 1'b0;
      end else begin
         bus.i_redirect    = ($urandom_range(999) < k_redir);
         bus.i_redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
      end
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         bus.i_imem_rvalid = 1'b1;
         bus.i_imem_rdata  = data_of(pend[0].addr);
      end else begin
         bus.i_imem_rvalid = 1'b0;
         bus.i_imem_rdata  = $urandom;
      end
      @(negedge clk);
      redir     = bus.i_redirect;
      exp_req   = !redir && (mfifo.size() + pend.size() < DEPTH);
      exp_valid = !redir && (mfifo.size() != 0);
      check("req", {31'd0, bus.o_imem_req}, {31'd0, exp_req});
      check("addr", bus.o_imem_addr, next_pc);
      check("valid", {31'd0, bus.o_inst_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         check("inst_pc", bus.o_inst_pc, mfifo[0]);
         check("inst", bus.o_inst, data_of(mfifo[0]));
      end
      if (bus.o_imem_req && bus.i_imem_gnt) dut_grants++;
      if (bus.o_inst_valid) valid_seen++;
      if (bus.i_imem_rvalid && pend.size() == 0)
         $fatal(1, "FAIL protocol: response with nothing outstanding");
      fire = exp_req && bus.i_imem_gnt;
      pop  = exp_valid && bus.i_inst_ready;
      if (pop) void'(mfifo.pop_front());
      if (bus.i_imem_rvalid) begin
         e = pend.pop_front();
         if (!redir && e.epoch == epoch) mfifo.push_back(e.addr);
      end
      if (redir) begin
         mfifo.delete();
         epoch++;
         next_pc = {bus.i_redirect_pc[31:2], 2'b00};
      end else if (fire) begin
         lat      = $urandom_range(k_lmax, k_lmin);
         e.addr   = next_pc;
         e.epoch  = epoch;
         e.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         last_due = e.due;
         pend.push_back(e);
         next_pc  = next_pc + 32'd4;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_redirect = 1'b0; bus.i_inst_ready = 1'b0;
      pend.delete(); mfifo.delete();
      next_pc  = RA;
      last_due = cyc;
      @(negedge clk);
      check("rst_req", {31'd0, bus.o_imem_req}, 32'd0);
      check("rst_addr", bus.o_imem_addr, 32'h0000_0100);
      check("rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      @(posedge clk);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (bus.o_inst_valid !== 1'b1 && n < budget) begin
         run_cycle();
         n++;
      end
      if (bus.o_inst_valid !== 1'b1) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: o_inst_valid stayed low for %0d cycles, required high", name, budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, v0;
      rst = 1'b1;
      bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
      bus.i_inst_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = '0;
      n_checks = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0; dut_grants = 0; valid_seen = 0;
      next_pc = RA; f_redir = 1'b0; f_redir_pc = '0;

      // Streaming from reset with single-cycle memory.
      knobs(100, 100, 0, 1, 1);
      do_reset();
      run_cycle(); check("s_addr0", bus.o_imem_addr, 32'h100); check("s_valid0", {31'd0, bus.o_inst_valid}, 32'd0);
      run_cycle(); check("s_addr1", bus.o_imem_addr, 32'h104); check("s_valid1", {31'd0, bus.o_inst_valid}, 32'd0);
      run_cycle(); check("s_valid2", {31'd0, bus.o_inst_valid}, 32'd1); check("s_pc2", bus.o_inst_pc, 32'h100);
      check("s_inst2", bus.o_inst, 32'h0100_FFFF ^ 32'h1357_9BDF);
      run_cycle(); check("s_pc3", bus.o_inst_pc, 32'h104);
      v0 = valid_seen;
      repeat (20) run_cycle();
      check("s_thruput", valid_seen - v0, 32'd20);

      // Backpressure until full, then a single pop.
      knobs(100, 0, 0, 1, 1);
      do_reset();
      g0 = dut_grants;
      repeat (8) run_cycle();
      check("bp_grants", dut_grants - g0, 32'd4);
      check("bp_req", {31'd0, bus.o_imem_req}, 32'd0);
      check("bp_pc", bus.o_inst_pc, 32'h100);
      k_rdy = 100; run_cycle();
      check("bp_pop_req", {31'd0, bus.o_imem_req}, 32'd0);
      k_rdy = 0; run_cycle();
      check("bp_req_again", {31'd0, bus.o_imem_req}, 32'd1);
      check("bp_addr_again", bus.o_imem_addr, 32'h110);
      repeat (3) run_cycle();
      check("bp_grants2", dut_grants - g0, 32'd5);
      check("bp_head", bus.o_inst_pc, 32'h104);

      // Latency 3 with random decode stalls.
      knobs(100, 60, 0, 3, 3);
      do_reset();
      repeat (150) run_cycle();

      // Redirect with three requests in flight, one response in the redirect cycle.
      knobs(100, 100, 0, 3, 3);
      do_reset();
      repeat (3) run_cycle();
      f_redir = 1'b1; f_redir_pc = 32'h2002;
      run_cycle();
      check("rd_req", {31'd0, bus.o_imem_req}, 32'd0);
      check("rd_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      run_cycle();
      check("rd_next_req", {31'd0, bus.o_imem_req}, 32'd1);
      check("rd_next_addr", bus.o_imem_addr, 32'h2000);
      wait_valid("rd_first", 20);
      check("rd_first_pc", bus.o_inst_pc, 32'h2000);

      // Redirect in the same cycle decode would pop.
      knobs(100, 0, 0, 1, 1);
      f_redir = 1'b1; f_redir_pc = 32'h10;
      run_cycle();
      wait_valid("rp_fill", 20);
      check("rp_head", bus.o_inst_pc, 32'h10);
      k_rdy = 100; f_redir = 1'b1; f_redir_pc = 32'h40;
      run_cycle();
      check("rp_valid_r", {31'd0, bus.o_inst_valid}, 32'd0);
      check("rp_req_r", {31'd0, bus.o_imem_req}, 32'd0);
      k_rdy = 0;
      run_cycle();
      check("rp_valid_n", {31'd0, bus.o_inst_valid}, 32'd0);
      check("rp_addr_n", bus.o_imem_addr, 32'h40);

      // Address wrap.
      knobs(100, 100, 0, 1, 1);
      f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
      run_cycle();
      run_cycle(); check("wr_addr0", bus.o_imem_addr, 32'hFFFF_FFFC);
      run_cycle(); check("wr_addr1", bus.o_imem_addr, 32'h0000_0000);
      run_cycle(); check("wr_pc0", bus.o_inst_pc, 32'hFFFF_FFFC);
      run_cycle(); check("wr_pc1", bus.o_inst_pc, 32'h0000_0000);

      // Random traffic with a reset in the middle.
      for (int blk = 0; blk < 15; blk++) begin
         int lmin;
         lmin = $urandom_range(3, 1);
         knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(60), lmin, lmin + $urandom_range(4));
         if (blk == 7) do_reset();
         repeat (200) run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
